// File: rtl/mic_array_frontend.sv
`default_nettype none
// ============================================================================
// Module   : mic_array_frontend
// Purpose  : N-channel I2S microphone front end. Generates one shared bit
//            clock and word clock for every mic. Captures each mic's
//            left-slot sample in lockstep and presents the frame once per
//            word period. Produces a delay-and-sum output from per-channel
//            integer-sample delay lines.
// Ports    : clk_in            system audio clock
//            rst_in            asynchronous active-low reset
//            enable_in         run capture; low parks the I2S clocks
//            mic_data_in       serial data, bit i from mic i
//            i2s_clk_out       shared bit clock
//            lrcl_clk_out      shared word clock (0 = left slot)
//            delay_in          per-channel delay, channel i at [i*DLY_W +: DLY_W]
//            chan_mask_in      1 = channel included in the sum
//            samples_out       latest undelayed frame, channel i at [i*DATA_W +: DATA_W]
//            sample_valid_out  one-cycle pulse when samples_out updates
//            sum_out           signed delay-and-sum result
//            sum_valid_out     one-cycle pulse when sum_out updates
// Revision : 1.0 - initial release
// ============================================================================
module mic_array_frontend #(
    parameter int N_CH      = 3,
    parameter int DATA_W    = 16,
    parameter int BCLK_DIV  = 16,
    parameter int MAX_DELAY = 32,
    parameter int DLY_W     = $clog2(MAX_DELAY),
    parameter int SUM_W     = DATA_W + $clog2(N_CH)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     enable_in,
    input  logic [N_CH-1:0]          mic_data_in,
    output logic                     i2s_clk_out,
    output logic                     lrcl_clk_out,
    input  logic [N_CH*DLY_W-1:0]    delay_in,
    input  logic [N_CH-1:0]          chan_mask_in,
    output logic [N_CH*DATA_W-1:0]   samples_out,
    output logic                     sample_valid_out,
    output logic signed [SUM_W-1:0]  sum_out,
    output logic                     sum_valid_out
);

    localparam int                 C_DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(BCLK_DIV - 1);
    localparam logic [5:0]         C_BIT_LAST = 6'd63;

    logic [C_DIV_W-1:0]      r_div;
    logic                    r_bclk;
    logic [5:0]              r_bit;
    logic [DLY_W-1:0]        r_wr_ptr;
    logic                    r_sample_valid;
    logic                    r_sum_valid;
    logic signed [SUM_W-1:0] r_sum;

    logic                    w_div_wrap;
    logic                    w_bclk_rise;
    logic                    w_bclk_fall;
    logic                    w_capture;
    logic                    w_frame_end;
    logic                    w_sum_go;
    logic signed [SUM_W-1:0] w_tap [N_CH];
    logic signed [SUM_W-1:0] w_sum;

    // Every event is qualified by enable_in through the divider wrap, so a
    // disabled front end can never produce an edge, a capture or a frame.
    assign w_div_wrap  = enable_in && (r_div == C_DIV_LAST);
    assign w_bclk_rise = w_div_wrap && !r_bclk;
    assign w_bclk_fall = w_div_wrap &&  r_bclk;
    assign w_frame_end = w_bclk_fall && (r_bit == C_BIT_LAST);
    // Left-slot data bits sit at b = 1..DATA_W; b = 0 is the I2S one-bit
    // delay slot and everything after DATA_W is padding or right slot.
    assign w_capture   = w_bclk_rise && (int'(r_bit) >= 1) && (int'(r_bit) <= DATA_W);
    assign w_sum_go    = r_sample_valid && enable_in;

    assign i2s_clk_out      = r_bclk;
    assign lrcl_clk_out     = r_bit[5];
    assign sample_valid_out = r_sample_valid;
    assign sum_valid_out    = r_sum_valid;
    assign sum_out          = r_sum;

    // ------------------------------------------------------------------
    // Bit clock divider and frame bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
            r_bit  <= '0;
        end else if (!enable_in) begin
            // Parking at b = 0 throws away any partial frame; the next
            // enable starts a fresh 64-bit frame.
            r_div  <= '0;
            r_bclk <= 1'b0;
            r_bit  <= '0;
        end else begin
            if (w_div_wrap) begin
                r_div  <= '0;
                r_bclk <= ~r_bclk;
            end else begin
                r_div  <= r_div + C_DIV_W'(1);
            end
            if (w_bclk_fall) begin
                r_bit <= r_bit + 6'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame strobe and shared delay-line write pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_sample_valid <= 1'b0;
            r_wr_ptr       <= '0;
        end else begin
            r_sample_valid <= w_frame_end;
            if (w_frame_end) begin
                r_wr_ptr <= r_wr_ptr + DLY_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel shift register, sample hold and delay line
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [DATA_W-1:0] r_shift;
        logic [DATA_W-1:0] r_hold;
        logic [DATA_W-1:0] r_line [MAX_DELAY];
        logic [DLY_W-1:0]  w_rd_idx;

        always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in) begin
                r_shift <= '0;
                r_hold  <= '0;
                for (int k = 0; k < MAX_DELAY; k++) begin
                    r_line[k] <= '0;
                end
            end else begin
                if (w_capture) begin
                    r_shift <= {r_shift[DATA_W-2:0], mic_data_in[gi]};
                end
                // Frame end is a falling bclk edge, never coincident with a
                // capture, so r_shift holds exactly bits 1..DATA_W here.
                if (w_frame_end) begin
                    r_hold           <= r_shift;
                    r_line[r_wr_ptr] <= r_shift;
                end
            end
        end

        // r_wr_ptr has already advanced past the newest entry, so delay 0
        // reads wr_ptr-1. DLY_W-bit arithmetic gives the modulo wrap.
        assign w_rd_idx  = r_wr_ptr - DLY_W'(1) - delay_in[gi*DLY_W +: DLY_W];
        assign w_tap[gi] = chan_mask_in[gi] ? SUM_W'($signed(r_line[w_rd_idx])) : '0;
        assign samples_out[gi*DATA_W +: DATA_W] = r_hold;
    end

    // ------------------------------------------------------------------
    // Delay-and-sum, registered one cycle after the frame strobe
    // ------------------------------------------------------------------
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_sum = w_sum + w_tap[i];
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
        end else begin
            r_sum_valid <= w_sum_go;
            if (w_sum_go) begin
                r_sum <= w_sum;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mic_array_frontend.sv
`default_nettype none
// ============================================================================
// Module   : tb_mic_array_frontend
// Purpose  : Self-checking bench for mic_array_frontend. Mic models shift
//            known words out MSB first; a frame-level history model predicts
//            every sample frame and every delay-and-sum result.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mic_array_frontend;

    localparam int N_CH      = 3;
    localparam int DATA_W    = 16;
    localparam int BCLK_DIV  = 8;
    localparam int MAX_DELAY = 32;
    localparam int DLY_W     = 5;
    localparam int SUM_W     = 18;
    localparam int BCLK_P    = 2 * BCLK_DIV;
    localparam int FRAME_P   = 64 * BCLK_P;

    logic                    clk_in = 1'b0;
    logic                    rst_in = 1'b0;
    logic                    enable_in = 1'b0;
    logic [N_CH-1:0]         mic_data_in;
    logic                    i2s_clk_out;
    logic                    lrcl_clk_out;
    logic [N_CH*DLY_W-1:0]   delay_in = '0;
    logic [N_CH-1:0]         chan_mask_in = '0;
    logic [N_CH*DATA_W-1:0]  samples_out;
    logic                    sample_valid_out;
    logic signed [SUM_W-1:0] sum_out;
    logic                    sum_valid_out;

    mic_array_frontend #(
        .N_CH(N_CH), .DATA_W(DATA_W), .BCLK_DIV(BCLK_DIV),
        .MAX_DELAY(MAX_DELAY), .DLY_W(DLY_W), .SUM_W(SUM_W)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
        .mic_data_in(mic_data_in), .i2s_clk_out(i2s_clk_out),
        .lrcl_clk_out(lrcl_clk_out), .delay_in(delay_in),
        .chan_mask_in(chan_mask_in), .samples_out(samples_out),
        .sample_valid_out(sample_valid_out), .sum_out(sum_out),
        .sum_valid_out(sum_valid_out)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Mic models and frame history
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mic_word [N_CH];
    logic [DATA_W-1:0] cur_word [N_CH];
    logic [DATA_W-1:0] hist     [N_CH][128];
    int bcnt  = 0;
    int fdone = 0;   // frames completed since time zero
    int fbase = 0;   // fdone at the most recent reset

    initial begin
        mic_data_in = '0;
        forever begin
            @(negedge i2s_clk_out or negedge rst_in or negedge enable_in);
            if (!rst_in) begin
                bcnt  = 0;
                fbase = fdone;
            end else if (!enable_in) begin
                bcnt = 0;
            end else begin
                bcnt = (bcnt + 1) % 64;
                if (bcnt == 1)
                    for (int c = 0; c < N_CH; c++) cur_word[c] = mic_word[c];
                if (bcnt == 0) begin
                    if (fdone - fbase < 128)
                        for (int c = 0; c < N_CH; c++) hist[c][fdone - fbase] = cur_word[c];
                    fdone = fdone + 1;
                end
                for (int c = 0; c < N_CH; c++) begin
                    if (bcnt >= 1 && bcnt <= DATA_W)
                        mic_data_in[c] = cur_word[c][DATA_W - bcnt];
                    else
                        mic_data_in[c] = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare process: every cycle out of reset
    // ------------------------------------------------------------------
    int seen = 0;
    bit pend = 1'b0;
    int pval = 0;

    initial begin
        forever begin
            @(negedge clk_in);
            if (!rst_in) begin
                seen = fdone;
                pend = 1'b0;
                continue;
            end
            check("sample_valid", longint'(sample_valid_out), longint'(fdone != seen));
            check("sum_valid", longint'(sum_valid_out), longint'(pend));
            if (pend) check("sum_model", longint'(sum_out), longint'(pval));
            pend = 1'b0;
            if (fdone != seen) begin
                int nf;
                nf = fdone - fbase;
                for (int c = 0; c < N_CH; c++)
                    check("samples_model", longint'(samples_out[c*DATA_W +: DATA_W]),
                          longint'(hist[c][nf-1]));
                pval = 0;
                for (int c = 0; c < N_CH; c++) begin
                    if (chan_mask_in[c]) begin
                        int k;
                        k = nf - 1 - int'(delay_in[c*DLY_W +: DLY_W]);
                        if (k >= 0) pval = pval + int'($signed(hist[c][k]));
                    end
                end
                seen = fdone;
                pend = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic timeout(input string name);
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL %s: got timeout required event", name);
    endtask

    task automatic wait_level(input int sel, input logic lvl, output int c);
        logic v;
        c = -1;
        for (int i = 0; i < 4 * FRAME_P; i++) begin
            tick();
            v = (sel == 0) ? i2s_clk_out : lrcl_clk_out;
            if (v == lvl) begin
                c = cyc;
                return;
            end
        end
        timeout("wait_level");
    endtask

    task automatic wait_valid(output int c);
        c = -1;
        for (int i = 0; i < 3 * FRAME_P; i++) begin
            tick();
            if (sample_valid_out) begin
                c = cyc;
                return;
            end
        end
        timeout("wait_valid");
    endtask

    task automatic get_sum(output int s);
        int c;
        wait_valid(c);
        tick();
        check("sum_valid_follow", longint'(sum_valid_out), 1);
        s = int'(sum_out);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_i2s"},  longint'(i2s_clk_out), 0);
        check({tag, "_lrcl"}, longint'(lrcl_clk_out), 0);
        check({tag, "_samples"}, longint'(samples_out), 0);
        check({tag, "_svalid"},  longint'(sample_valid_out), 0);
        check({tag, "_sum"},     longint'(sum_out), 0);
        check({tag, "_sumvalid"}, longint'(sum_valid_out), 0);
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        int c0, c1, c2, cr, cf, cr2, s, e;

        mic_word[0] = 16'h1234;
        mic_word[1] = 16'h8000;
        mic_word[2] = 16'h7FFF;
        chan_mask_in = 3'b111;
        delay_in     = '0;
        enable_in    = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");

        // Clock timing after release
        rst_in = 1'b1;
        c0 = cyc;
        wait_level(0, 1'b1, c1);
        wait_level(0, 1'b0, c2);
        wait_level(0, 1'b1, c2);
        check("bclk_period", longint'(c2 - c1), BCLK_P);
        wait_level(1, 1'b1, cr);
        check("lrcl_low_len", longint'(cr - c0), FRAME_P / 2);
        wait_level(1, 1'b0, cf);
        wait_level(1, 1'b1, cr2);
        check("lrcl_high_len", longint'(cf - cr), FRAME_P / 2);
        check("lrcl_period", longint'(cr2 - cr), FRAME_P);

        // Capture and sum with literal expectations
        wait_valid(c1);
        check("capture_frame", longint'(samples_out), 48'h7FFF_8000_1234);
        tick();
        check("svalid_one_cycle", longint'(sample_valid_out), 0);
        check("sum_valid_lit", longint'(sum_valid_out), 1);
        check("sum_all3", longint'(sum_out), 4659);
        chan_mask_in = 3'b010;
        get_sum(s);
        check("sum_ch1_only", longint'(s), -32768);

        // Asynchronous reset mid-frame
        repeat (100) tick();
        rst_in = 1'b0;
        #1;
        check_all_zero("async_rst");
        mic_word[0]  = 16'd1;
        chan_mask_in = 3'b001;
        delay_in[0 +: DLY_W] = 5'd3;
        repeat (3) tick();
        rst_in = 1'b1;

        // ch0 ramp: delay 3 for six frames, then delay 31
        for (int f = 1; f <= 34; f++) begin
            get_sum(s);
            if (f <= 6) e = (f <= 3) ? 0 : f - 3;
            else        e = (f >= 32) ? f - 31 : 0;
            check("ramp_sum", longint'(s), longint'(e));
            mic_word[0] = 16'(f + 1);
            if (f == 6) delay_in[0 +: DLY_W] = 5'd31;
        end

        // Enable drop at b=40, re-enable
        mic_word[0] = 16'h0ABC;
        mic_word[1] = 16'h0DEF;
        mic_word[2] = 16'h0123;
        wait_valid(c1);
        for (int i = 0; i < FRAME_P && bcnt != 40; i++) tick();
        if (bcnt != 40) timeout("wait_b40");
        enable_in = 1'b0;
        repeat (2) tick();
        check("dis_i2s", longint'(i2s_clk_out), 0);
        check("dis_lrcl", longint'(lrcl_clk_out), 0);
        mic_word[0] = 16'h5A5A;
        mic_word[1] = 16'hA5A5;
        mic_word[2] = 16'hFFFF;
        repeat (300) tick();
        enable_in = 1'b1;
        c0 = cyc;
        wait_valid(c1);
        check("reenable_latency", longint'(c1 - c0), FRAME_P);
        check("reenable_frame", longint'(samples_out), 48'hFFFF_A5A5_5A5A);

        // ch1 delay switch 0 -> 5 between frames
        chan_mask_in = 3'b010;
        delay_in     = '0;
        mic_word[1]  = 16'h0100;
        for (int k = 0; k <= 7; k++) begin
            get_sum(s);
            e = (k <= 5) ? 256 + k : 256 + k - 5;
            check("dly_switch_sum", longint'(s), longint'(e));
            mic_word[1] = 16'(256 + k + 1);
            if (k == 5) delay_in[DLY_W +: DLY_W] = 5'd5;
        end

        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mic_array_frontend.md
Name: mic_array_frontend

Overview:
- Parametrised N-channel I2S microphone front end: generates one shared bit clock and word clock for all mics and captures every mic's left-slot sample in lockstep.
- Presents the sample frame once per word period, then produces a delay-and-sum output from per-channel integer-sample delay lines.
- Sits between the pmod mic pins and the downstream audio path (anti-alias filter, speed-of-sound calculator, pdm). Supersedes the per-mic receiver instances and the per-mic sample-hold registers.

Parameters:
N_CH, 3, number of microphone channels (1..8)
DATA_W, 16, captured sample width; top DATA_W bits of the mic word, two's complement
BCLK_DIV, 16, clk_in cycles per i2s_clk half-period (98.3 MHz gives 3.07 MHz bclk, 48 kHz frame)
MAX_DELAY, 32, delay line depth in samples (power of two)
DLY_W, $clog2(MAX_DELAY), width of one channel's delay field
SUM_W, DATA_W+$clog2(N_CH), width of the delay-and-sum result

Ports:
clk_in  input  1  system audio clock
rst_in  input  1  asynchronous, active-low reset
enable_in  input  1  run capture; low parks the I2S clocks
mic_data_in  input  N_CH  serial data, bit i from mic i
i2s_clk_out  output  1  shared bit clock to all mics
lrcl_clk_out  output  1  shared word clock to all mics
delay_in  input  N_CH*DLY_W  per-channel delay in samples; channel i at [i*DLY_W +: DLY_W]
chan_mask_in  input  N_CH  1 = channel included in the sum
samples_out  output  N_CH*DATA_W  latest undelayed frame; channel i at [i*DATA_W +: DATA_W]
sample_valid_out  output  1  one-cycle pulse when samples_out updates
sum_out  output  SUM_W  signed delay-and-sum result
sum_valid_out  output  1  one-cycle pulse when sum_out updates

Behaviour:
- Reset (rst_in low, asynchronous):
  - All outputs go to 0.
  - Divider, bit counter and write pointer clear.
  - All delay-line entries clear to 0.
- Clock generation:
  - The divider counts 0..BCLK_DIV-1. i2s_clk_out toggles on each wrap, so one bclk period is 2*BCLK_DIV cycles.
  - The bit counter b (0..63) advances on each i2s_clk falling edge, so one frame is 64 bclk periods.
  - lrcl_clk_out is 0 for b=0..31 and 1 for b=32..63.
- Capture:
  - On the clk_in cycle in which i2s_clk_out rises, for b=1..DATA_W, shift mic_data_in[i] into channel i's shift register, MSB first (MSB at b=1).
  - All other bits are ignored, including the right slot and the mic's tristated bits.
- Frame end (b 63 -> 0 wrap, cycle T):
  - samples_out loads all shift registers and sample_valid_out pulses at T.
  - Each channel's sample is written to its delay line at wr_ptr; wr_ptr then increments modulo MAX_DELAY.
- Sum:
  - At T+1, sum_out = sum over channels with chan_mask_in[i]=1 of line_i[wr_ptr-1-d_i], sign-extended to SUM_W. sum_valid_out pulses at T+1.
  - d_i=0 selects the sample written at T.
  - The delay_in and chan_mask_in values sampled at T+1 are used; a mid-frame change takes effect at the next sum.
  - Entries never written since reset read as 0.
  - Mask all zero gives sum_out 0, with sum_valid_out still pulsing.
- enable_in low:
  - i2s_clk_out and lrcl_clk_out are held 0; divider and b are held at 0.
  - No valid pulses; any partial frame is discarded.
  - Delay lines, wr_ptr, samples_out and sum_out hold their values.
  - On enable_in rising, the frame starts at b=0; the first valid pulse follows 64 bclk periods later.
- Arithmetic: the sum is exact (SUM_W has no overflow for N_CH channels); no saturation or rounding.

Test Plan:
- Reset: rst_in low mid-frame with nonzero samples -> all outputs 0 within the same cycle; after release with enable_in=1, i2s_clk period 32 cycles, lrcl period 2048 cycles, lrcl low for the first 1024.
- Capture: mic models drive 0x1234, 0x8000, 0x7FFF MSB-first on b=1..16 -> samples_out = {0x7FFF,0x8000,0x1234}, sample_valid_out one cycle at the frame wrap.
- Sum: same stimulus, mask 3'b111, delays 0 -> sum_out = 18'sd4659 (0x01233) one cycle after sample_valid_out; mask 3'b010 -> sum_out = -32768.
- Delay: ch0 ramps 1,2,3,..., mask 3'b001, delay 3 -> the first 3 sums are 0, then sum_out = 1,2,3,... lagging samples_out by 3 frames. Delay 31 -> lag 31.
- Enable: drop enable_in at b=40 -> clocks go to 0, no pulses, partial frame discarded. Re-enable -> next sample_valid_out exactly 2048 cycles later with a full new sample.
- Delay change: switch ch1 delay 0 -> 5 between frames -> the next sum uses the sample from 5 frames earlier, with no spurious extra valid pulse.
